// File: rtl/game_timer_ctrl.sv
// Round timer sequencer: gates the tick prescaler and counts its timeouts down
// from a loaded value, with pause/resume, restart and abort.
module game_timer_ctrl #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick_in,
  output logic             presc_en,
  output logic             presc_rst_n,
  output logic [CNT_W-1:0] remaining,
  output logic             busy,
  output logic             expired,
  output logic [1:0]       state
);

  // state  | meaning
  // IDLE   | no round; prescaler disabled, remaining = 0
  // RUN    | prescaler enabled, tick_in decrements remaining
  // PAUSED | prescaler frozen mid-interval, ticks discarded
  // DONE   | reached zero; waits for start or abort
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_d;
  logic             exp_d;
  logic             prn_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining   <= '0;
      expired     <= 1'b0;
      presc_rst_n <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining   <= rem_d;
      expired     <= exp_d;
      presc_rst_n <= prn_d;
    end
  end

  // Any start pulse, even a rejected zero load, consumes the cycle.
  always_comb begin
    state_d = state_q;
    rem_d   = remaining;
    exp_d   = 1'b0;
    prn_d   = 1'b1;
    if (abort) begin
      state_d = IDLE;
      rem_d   = '0;
    end else if (start) begin
      if (load_val != '0) begin
        state_d = RUN;
        rem_d   = load_val;
        prn_d   = 1'b0;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (tick_in && remaining != '0) begin
            rem_d = remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state_d = DONE;
              exp_d   = 1'b1;
            end else if (pause) begin
              state_d = PAUSED;
            end
          end else if (pause) begin
            state_d = PAUSED;
          end
        end
        PAUSED: if (pause) state_d = RUN;
        default: ;
      endcase
    end
  end

  assign state    = state_q;
  assign presc_en = (state_q == RUN);
  assign busy     = (state_q == RUN) || (state_q == PAUSED);

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: directed scenarios with literal expectations plus
// a random phase, all outputs checked every cycle against a behavioural model.
module tb_game_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, pause = 1'b0, abort = 1'b0, tick_in = 1'b0;
  logic [6:0] load_val = '0;
  logic       presc_en, presc_rst_n, busy, expired;
  logic [6:0] remaining;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  game_timer_ctrl #(.CNT_W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .load_val(load_val), .tick_in(tick_in), .presc_en(presc_en),
    .presc_rst_n(presc_rst_n), .remaining(remaining), .busy(busy),
    .expired(expired), .state(state)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 running, 2 paused, 3 done; rem counts units left.
  int m_st = 0, m_rem = 0;
  bit m_exp = 0, m_prn = 0, m_valid = 0;
  bit s_rst, s_start, s_pause, s_abort, s_tick;
  int s_lv;

  always @(posedge clk) begin
    s_rst = rst; s_start = start; s_pause = pause; s_abort = abort;
    s_tick = tick_in; s_lv = int'(load_val);
    if (s_rst) begin
      m_st = 0; m_rem = 0; m_exp = 0; m_prn = 0; m_valid = 1;
    end else begin
      m_exp = 0;
      m_prn = 1;
      if (s_abort) begin
        m_st = 0; m_rem = 0;
      end else if (s_start) begin
        if (s_lv > 0) begin
          m_st = 1; m_rem = s_lv; m_prn = 0;
        end
      end else if (m_st == 1 && s_tick) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_st = 3; m_exp = 1;
        end else if (s_pause) m_st = 2;
      end else if (s_pause && m_st == 1) m_st = 2;
      else if (s_pause && m_st == 2) m_st = 1;
    end
    #1;
    if (m_valid) begin
      total++;
      if (int'(state) != m_st || int'(remaining) != m_rem || expired != m_exp ||
          presc_rst_n != m_prn || presc_en != (m_st == 1) ||
          busy != (m_st == 1 || m_st == 2)) begin
        bad++;
        $display("FAIL model t=%0t: got st=%0d rem=%0d exp=%0b prn=%0b en=%0b busy=%0b want st=%0d rem=%0d exp=%0b prn=%0b",
                 $time, state, remaining, expired, presc_rst_n, presc_en, busy,
                 m_st, m_rem, m_exp, m_prn);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then return #1 after the edge that sampled them.
  task automatic cyc(input bit r, input bit s, input bit p, input bit a,
                     input bit t, input int lv);
    rst = r; start = s; pause = p; abort = a; tick_in = t; load_val = 7'(lv);
    @(posedge clk);
    #1;
    rst = 0; start = 0; pause = 0; abort = 0; tick_in = 0; load_val = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset then release
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_state", state, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_prn", presc_rst_n, 0);
    chk("rst_en", presc_en, 0);
    idle(1);
    chk("rel_prn", presc_rst_n, 1);

    // load 3, ticks 10 cycles apart
    cyc(0, 1, 0, 0, 0, 3);
    chk("s3_state", state, 1);
    chk("s3_rem", remaining, 3);
    chk("s3_prn", presc_rst_n, 0);
    chk("s3_en", presc_en, 1);
    idle(1);
    chk("s3_prn_hi", presc_rst_n, 1);
    for (int i = 2; i >= 0; i--) begin
      idle(9);
      cyc(0, 0, 0, 0, 1, 0);
      chk("s3_tick_rem", remaining, i);
      chk("s3_tick_exp", expired, (i == 0) ? 1 : 0);
    end
    chk("s3_done", state, 3);
    chk("s3_done_en", presc_en, 0);
    idle(1);
    chk("s3_exp_drop", expired, 0);

    // pause holds the count
    cyc(0, 1, 0, 0, 0, 5);
    cyc(0, 0, 0, 0, 1, 0);
    chk("p_rem4", remaining, 4);
    cyc(0, 0, 1, 0, 0, 0);
    chk("p_state", state, 2);
    chk("p_en", presc_en, 0);
    repeat (4) cyc(0, 0, 0, 0, 1, 0);
    chk("p_hold", remaining, 4);
    cyc(0, 0, 1, 0, 0, 0);
    chk("p_resume", state, 1);
    chk("p_resume_prn", presc_rst_n, 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("p_rem3", remaining, 3);

    // expiring tick beats pause
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 1, 0);
    chk("tp_state", state, 3);
    chk("tp_rem", remaining, 0);
    chk("tp_exp", expired, 1);

    // zero start ignored, restart mid-run
    cyc(0, 0, 0, 1, 0, 0);
    chk("ab_done", state, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("z_state", state, 0);
    chk("z_en", presc_en, 0);
    cyc(0, 1, 0, 0, 0, 2);
    cyc(0, 0, 0, 0, 1, 0);
    chk("rs_rem1", remaining, 1);
    cyc(0, 1, 0, 0, 0, 2);
    chk("rs_rem2", remaining, 2);
    chk("rs_prn", presc_rst_n, 0);
    idle(1);
    chk("rs_prn_hi", presc_rst_n, 1);

    // abort wins over start
    cyc(0, 1, 0, 1, 0, 9);
    chk("as_state", state, 0);
    chk("as_rem", remaining, 0);

    // reset mid-round with a tick
    cyc(0, 1, 0, 0, 0, 6);
    cyc(1, 0, 0, 0, 1, 0);
    chk("rr_state", state, 0);
    chk("rr_rem", remaining, 0);
    chk("rr_prn", presc_rst_n, 0);
    chk("rr_exp", expired, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rr_prn2", presc_rst_n, 0);
    idle(1);
    chk("rr_prn_hi", presc_rst_n, 1);

    // random phase
    for (int i = 0; i < 4000; i++) begin
      bit r, s, p, a, t;
      int lv;
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 29) == 0);
      a  = ($urandom_range(0, 79) == 0);
      p  = ($urandom_range(0, 14) == 0);
      t  = ($urandom_range(0, 3) == 0);
      lv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
      if ($urandom_range(0, 49) == 0) lv = 127;
      cyc(r, s, p, a, t, lv);
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_timer_ctrl.md
# game_timer_ctrl

Sequencing controller for the 100-count tick prescaler. It enables the prescaler only while a round is running and restarts the prescaler phase on every (re)start. It counts prescaler timeout pulses down from a loaded value and flags expiry, with pause, resume, restart and abort. It sits between the game FSM (command pulses) and the prescaler/display (enable, prescaler reset, remaining count).

## Interface
Parameters:
- CNT_W, 7, width of the loaded and remaining count (units = prescaler timeouts)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- start  in  1  single-cycle pulse; load `load_val` and run (also restarts from RUN/PAUSED/DONE)
- pause  in  1  single-cycle pulse; toggles RUN <-> PAUSED, ignored in IDLE/DONE
- abort  in  1  single-cycle pulse; return to IDLE from any state
- load_val  in  CNT_W  start value, sampled only on an accepted `start`
- tick_in  in  1  prescaler timeout pulse (one cycle per 100 prescaler inputs)
- presc_en  out  1  prescaler enable, =1 iff state==RUN
- presc_rst_n  out  1  active-low prescaler clear, registered
- remaining  out  CNT_W  units left
- busy  out  1  =1 in RUN or PAUSED
- expired  out  1  single-cycle pulse on reaching zero
- state  out  2  IDLE=0, RUN=1, PAUSED=2, DONE=3

## Operation
- Reset values (cycle after `rst` sampled high): state=IDLE, remaining=0, expired=0, presc_rst_n=0, presc_en=0, busy=0. presc_rst_n returns to 1 on the first clock edge with rst=0.
- Priority per cycle: rst > abort > start > tick_in > pause.
- IDLE: presc_en=0, remaining holds 0.
  - start with load_val!=0 -> RUN.
  - start with load_val==0 -> ignored; stay IDLE, no expired pulse.
- Accepted start (any state, load_val!=0): remaining<=load_val, state<=RUN, presc_rst_n<=0 for exactly one cycle.
- Start with load_val==0 in RUN/PAUSED/DONE: ignored; state and remaining unchanged.
- RUN: tick_in=1 -> remaining<=remaining-1.
  - If remaining==1: remaining<=0, state<=DONE, expired<=1 for one cycle.
  - pause without tick -> PAUSED.
  - tick and pause in the same cycle: the decrement applies and state goes to PAUSED. If that tick expires, DONE wins and pause is dropped.
- PAUSED: presc_en=0, so the prescaler freezes its internal count. tick_in ignored. pause -> RUN, with no prescaler clear, so the partial interval is preserved.
- DONE: remaining=0, presc_en=0. tick_in and pause are ignored. start reloads; abort -> IDLE.
- abort: state<=IDLE, remaining<=0, expired<=0, presc_rst_n unchanged (1).
- remaining never wraps: decrement occurs only when remaining>=1 in RUN.
- tick_in received while state!=RUN is discarded; it is never queued.

## Timing
- All outputs are registered or decoded from registered state; no input-to-output combinational path.
- start sampled at edge n -> state=RUN, remaining=load_val, presc_en=1, presc_rst_n=0 during cycle n..n+1. presc_rst_n=1 from edge n+1.
  - The prescaler's synchronous clear at edge n+1 overrides its enable, so the first full 100-count interval starts at edge n+1.
- tick_in sampled at edge m (RUN) -> remaining decremented from edge m.
  - On expiry, expired=1, state=DONE and presc_en=0 from edge m. expired returns to 0 at edge m+1.
- pause sampled at edge p -> presc_en changes from edge p (1 cycle latency).
- rst asserted mid-round -> reset values from the next edge regardless of other inputs. rst held for k cycles keeps presc_rst_n=0 for those k cycles.
- Back-to-back commands on consecutive cycles are all honoured (no busy/ready handshake; each pulse is evaluated the cycle it is sampled).

## Test plan
- Reset then start, load_val=3, three tick_in pulses 10 cycles apart -> remaining 3,2,1,0. expired single pulse on the third tick edge. state 1->3. presc_rst_n low for exactly one cycle after start.
- load_val=5, tick, pause, 4 ticks while PAUSED, pause, tick -> remaining 4, held 4 during PAUSED with presc_en=0, then 3. No expired.
- load_val=1, tick_in and pause in the same cycle -> state=DONE, remaining=0, expired=1; pause ignored.
- start load_val=0 in IDLE -> no state change, presc_en=0. Then start load_val=2 while RUN at remaining=1 -> remaining=2, presc_rst_n one-cycle low.
- abort and start in the same cycle while RUN -> IDLE, remaining=0. Abort in DONE -> IDLE.
- rst asserted while RUN with remaining=6, concurrent tick_in -> IDLE, remaining=0, presc_rst_n=0 while rst high, expired never asserted.
